// File: rtl/chess_clock_ctrl_if.sv
// Button/expiry inputs and counter-chain control outputs of the chess clock controller.
// The master side is the button/counter fabric; the slave side is the controller.
interface chess_clock_ctrl_if #(
    parameter int MOVE_W = 8
);
    logic              TICK;
    logic              BTN_START;
    logic              BTN_PAUSE;
    logic              BTN_A;
    logic              BTN_B;
    logic              EXP_A;
    logic              EXP_B;
    logic              CE_A;
    logic              CE_B;
    logic              LOAD;
    logic              ACTIVE_A;
    logic              ACTIVE_B;
    logic              FLAG_A;
    logic              FLAG_B;
    logic [MOVE_W-1:0] MOVES;
    logic [2:0]        STATE;

    modport master (
        output TICK, BTN_START, BTN_PAUSE, BTN_A, BTN_B, EXP_A, EXP_B,
        input  CE_A, CE_B, LOAD, ACTIVE_A, ACTIVE_B, FLAG_A, FLAG_B, MOVES, STATE
    );

    modport slave (
        input  TICK, BTN_START, BTN_PAUSE, BTN_A, BTN_B, EXP_A, EXP_B,
        output CE_A, CE_B, LOAD, ACTIVE_A, ACTIVE_B, FLAG_A, FLAG_B, MOVES, STATE
    );
endinterface

// File: rtl/chess_clock_ctrl.sv
// Two-player chess clock game FSM: gates and presets the per-player counter chains,
// tracks turns, detects flag fall and counts completed full moves.
module chess_clock_ctrl #(
    parameter int MOVE_W = 8,
    parameter bit BLINK  = 1'b1
) (
    input logic               CLK,
    input logic               CLR,
    chess_clock_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN_A   = 3'd1,
        RUN_B   = 3'd2,
        PAUSE   = 3'd3,
        TIMEOUT = 3'd4
    } state_t;

    localparam logic [MOVE_W-1:0] MOVES_MAX = '1;

    // Kept as a plain vector so the unused codes 5-7 are representable and recoverable.
    logic [2:0]        state_q;
    logic              side_q;   // whose turn (0=A, 1=B); in TIMEOUT, the loser
    logic              flag_q;   // current phase of the loser's flag
    logic [MOVE_W-1:0] moves_q;

    state_t            nxt_state;
    logic              nxt_side;
    logic              nxt_flag;
    logic [MOVE_W-1:0] nxt_moves;

    // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
    always_comb begin
        nxt_state = state_t'(state_q);
        nxt_side  = side_q;
        nxt_moves = moves_q;
        nxt_flag  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.BTN_START) nxt_state = RUN_A;
            end
            RUN_A: begin
                if (bus.EXP_A) begin
                    nxt_state = TIMEOUT;
                    nxt_side  = 1'b0;
                end else if (bus.BTN_PAUSE) begin
                    nxt_state = PAUSE;
                    nxt_side  = 1'b0;
                end else if (bus.BTN_A) begin
                    nxt_state = RUN_B;
                    nxt_side  = 1'b1;
                end
            end
            RUN_B: begin
                if (bus.EXP_B) begin
                    nxt_state = TIMEOUT;
                    nxt_side  = 1'b1;
                end else if (bus.BTN_PAUSE) begin
                    nxt_state = PAUSE;
                    nxt_side  = 1'b1;
                end else if (bus.BTN_B) begin
                    nxt_state = RUN_A;
                    nxt_side  = 1'b0;
                    if (moves_q != MOVES_MAX) nxt_moves = moves_q + MOVE_W'(1);
                end
            end
            PAUSE: begin
                if (bus.BTN_PAUSE)      nxt_state = IDLE;
                else if (bus.BTN_START) nxt_state = side_q ? RUN_B : RUN_A;
            end
            TIMEOUT: begin
                if (bus.BTN_START) nxt_state = IDLE;
            end
            default: nxt_state = IDLE;
        endcase

        if (nxt_state == IDLE) begin
            nxt_side  = 1'b0;
            nxt_moves = '0;
        end

        // Flag rises on entry; while held in TIMEOUT it optionally blinks with TICK.
        if (nxt_state == TIMEOUT) begin
            if (state_q != TIMEOUT)    nxt_flag = 1'b1;
            else if (BLINK && bus.TICK) nxt_flag = ~flag_q;
            else                        nxt_flag = flag_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q      <= IDLE;
            side_q       <= 1'b0;
            flag_q       <= 1'b0;
            moves_q      <= '0;
            bus.STATE    <= IDLE;
            bus.LOAD     <= 1'b1;
            bus.CE_A     <= 1'b0;
            bus.CE_B     <= 1'b0;
            bus.ACTIVE_A <= 1'b0;
            bus.ACTIVE_B <= 1'b0;
            bus.FLAG_A   <= 1'b0;
            bus.FLAG_B   <= 1'b0;
            bus.MOVES    <= '0;
        end else begin
            state_q      <= nxt_state;
            side_q       <= nxt_side;
            flag_q       <= nxt_flag;
            moves_q      <= nxt_moves;
            bus.STATE    <= nxt_state;
            bus.LOAD     <= (nxt_state == IDLE);
            bus.CE_A     <= (nxt_state == RUN_A);
            bus.CE_B     <= (nxt_state == RUN_B);
            bus.ACTIVE_A <= (nxt_state == RUN_A) || ((nxt_state == PAUSE) && !nxt_side);
            bus.ACTIVE_B <= (nxt_state == RUN_B) || ((nxt_state == PAUSE) &&  nxt_side);
            bus.FLAG_A   <= (nxt_state == TIMEOUT) && !nxt_side && nxt_flag;
            bus.FLAG_B   <= (nxt_state == TIMEOUT) &&  nxt_side && nxt_flag;
            bus.MOVES    <= nxt_moves;
        end
    end

endmodule

// File: tb/tb_chess_clock_ctrl.sv
// Scoreboard bench for chess_clock_ctrl: a MOVE_W=8/BLINK=1 instance and a MOVE_W=2/BLINK=0
// instance share one stimulus stream; expected outputs are queued per cycle and compared per test.
module tb_chess_clock_ctrl;

    logic CLK = 1'b0;
    logic CLR;

    always #5 CLK = ~CLK;

    chess_clock_ctrl_if #(.MOVE_W(8)) bus  ();
    chess_clock_ctrl_if #(.MOVE_W(2)) bus2 ();

    chess_clock_ctrl #(.MOVE_W(8), .BLINK(1'b1)) dut  (.CLK(CLK), .CLR(CLR), .bus(bus.slave));
    chess_clock_ctrl #(.MOVE_W(2), .BLINK(1'b0)) dut2 (.CLK(CLK), .CLR(CLR), .bus(bus2.slave));

    assign bus2.TICK      = bus.TICK;
    assign bus2.BTN_START = bus.BTN_START;
    assign bus2.BTN_PAUSE = bus.BTN_PAUSE;
    assign bus2.BTN_A     = bus.BTN_A;
    assign bus2.BTN_B     = bus.BTN_B;
    assign bus2.EXP_A     = bus.EXP_A;
    assign bus2.EXP_B     = bus.EXP_B;

    // Input vector bits: {CLR, START, PAUSE, A, B, EXP_A, EXP_B, TICK}
    localparam logic [7:0] I_NONE  = 8'h00;
    localparam logic [7:0] I_CLR   = 8'h80;
    localparam logic [7:0] I_START = 8'h40;
    localparam logic [7:0] I_PAUSE = 8'h20;
    localparam logic [7:0] I_A     = 8'h10;
    localparam logic [7:0] I_B     = 8'h08;
    localparam logic [7:0] I_EA    = 8'h04;
    localparam logic [7:0] I_EB    = 8'h02;
    localparam logic [7:0] I_TICK  = 8'h01;

    typedef struct packed {
        logic [2:0] st;
        logic       ce_a;
        logic       ce_b;
        logic       load;
        logic       act_a;
        logic       act_b;
        logic       fl_a;
        logic       fl_b;
        logic [7:0] mv;
        logic [2:0] st2;
        logic [1:0] mv2;
        logic       fl2_a;
        logic       fl2_b;
    } obs_t;

    obs_t exp_q[$];
    obs_t obs_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Drive one cycle of stimulus, queue the expected outputs, capture what both DUTs produce.
    // side: turn owner in PAUSE, loser in TIMEOUT.
    task automatic step(input logic [7:0] in, input logic [2:0] st, input logic side,
                        input logic fa, input logic fb, input int mv);
        obs_t e;
        obs_t o;
        @(negedge CLK);
        {CLR, bus.BTN_START, bus.BTN_PAUSE, bus.BTN_A, bus.BTN_B,
         bus.EXP_A, bus.EXP_B, bus.TICK} = in;
        e = '0;
        e.st  = st;
        e.st2 = st;
        case (st)
            3'd0: e.load = 1'b1;
            3'd1: begin e.ce_a = 1'b1; e.act_a = 1'b1; end
            3'd2: begin e.ce_b = 1'b1; e.act_b = 1'b1; end
            3'd3: begin e.act_a = !side; e.act_b = side; end
            3'd4: begin
                e.fl_a  = fa;
                e.fl_b  = fb;
                e.fl2_a = !side;
                e.fl2_b = side;
            end
            default: ;
        endcase
        e.mv  = mv[7:0];
        e.mv2 = (mv > 3) ? 2'd3 : mv[1:0];
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        o = '0;
        o.st    = bus.STATE;
        o.ce_a  = bus.CE_A;
        o.ce_b  = bus.CE_B;
        o.load  = bus.LOAD;
        o.act_a = bus.ACTIVE_A;
        o.act_b = bus.ACTIVE_B;
        o.fl_a  = bus.FLAG_A;
        o.fl_b  = bus.FLAG_B;
        o.mv    = bus.MOVES;
        o.st2   = bus2.STATE;
        o.mv2   = bus2.MOVES;
        o.fl2_a = bus2.FLAG_A;
        o.fl2_b = bus2.FLAG_B;
        obs_q.push_back(o);
    endtask

    task automatic test_reset();
        obs_t e, o;
        int   idx = 0;
        step(I_CLR | I_START, 3'd0, 1'b0, 1'b0, 1'b0, 0);
        step(I_NONE,          3'd0, 1'b0, 1'b0, 1'b0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL reset[%0d] got %p expected %p", idx, o, e);
            else         n_pass++;
            idx++;
        end
    endtask

    task automatic test_turns();
        obs_t e, o;
        int   idx = 0;
        step(I_START, 3'd1, 1'b0, 1'b0, 1'b0, 0);
        step(I_A,     3'd2, 1'b1, 1'b0, 1'b0, 0);
        step(I_B,     3'd1, 1'b0, 1'b0, 1'b0, 1);
        step(I_B,     3'd1, 1'b0, 1'b0, 1'b0, 1);  // B out of turn
        step(I_A,     3'd2, 1'b1, 1'b0, 1'b0, 1);
        step(I_A,     3'd2, 1'b1, 1'b0, 1'b0, 1);  // A out of turn
        step(I_B,     3'd1, 1'b0, 1'b0, 1'b0, 2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL turns[%0d] got %p expected %p", idx, o, e);
            else         n_pass++;
            idx++;
        end
    endtask

    task automatic test_pause();
        obs_t e, o;
        int   idx = 0;
        step(I_A,     3'd2, 1'b1, 1'b0, 1'b0, 2);
        step(I_PAUSE, 3'd3, 1'b1, 1'b0, 1'b0, 2);
        step(I_B,     3'd3, 1'b1, 1'b0, 1'b0, 2);  // player buttons ignored while paused
        step(I_START, 3'd2, 1'b1, 1'b0, 1'b0, 2);
        step(I_PAUSE, 3'd3, 1'b1, 1'b0, 1'b0, 2);
        step(I_PAUSE, 3'd0, 1'b0, 1'b0, 1'b0, 0);
        step(I_A,     3'd0, 1'b0, 1'b0, 1'b0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL pause[%0d] got %p expected %p", idx, o, e);
            else         n_pass++;
            idx++;
        end
    endtask

    task automatic test_clr_mid_game();
        obs_t e, o;
        int   idx = 0;
        step(I_START, 3'd1, 1'b0, 1'b0, 1'b0, 0);
        for (int k = 1; k <= 5; k++) begin
            step(I_A, 3'd2, 1'b1, 1'b0, 1'b0, k - 1);
            step(I_B, 3'd1, 1'b0, 1'b0, 1'b0, k);
        end
        step(I_A,         3'd2, 1'b1, 1'b0, 1'b0, 5);
        step(I_CLR | I_B, 3'd0, 1'b0, 1'b0, 1'b0, 0);
        step(I_NONE,      3'd0, 1'b0, 1'b0, 1'b0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL clr_mid_game[%0d] got %p expected %p", idx, o, e);
            else         n_pass++;
            idx++;
        end
    endtask

    task automatic test_timeout();
        obs_t e, o;
        int   idx = 0;
        step(I_START,          3'd1, 1'b0, 1'b0, 1'b0, 0);
        step(I_EA | I_A,       3'd4, 1'b0, 1'b1, 1'b0, 0);  // flag fall beats the move
        step(I_EA | I_TICK,    3'd4, 1'b0, 1'b0, 1'b0, 0);
        step(I_EA,             3'd4, 1'b0, 1'b0, 1'b0, 0);
        step(I_TICK | I_A,     3'd4, 1'b0, 1'b1, 1'b0, 0);
        step(I_PAUSE,          3'd4, 1'b0, 1'b1, 1'b0, 0);
        step(I_TICK,           3'd4, 1'b0, 1'b0, 1'b0, 0);
        step(I_START,          3'd0, 1'b0, 1'b0, 1'b0, 0);
        step(I_START,          3'd1, 1'b0, 1'b0, 1'b0, 0);
        step(I_A,              3'd2, 1'b1, 1'b0, 1'b0, 0);
        step(I_EB | I_PAUSE,   3'd4, 1'b1, 1'b0, 1'b1, 0);
        step(I_EB,             3'd4, 1'b1, 1'b0, 1'b1, 0);
        step(I_START,          3'd0, 1'b0, 1'b0, 1'b0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL timeout[%0d] got %p expected %p", idx, o, e);
            else         n_pass++;
            idx++;
        end
    endtask

    task automatic test_saturation();
        obs_t e, o;
        int   idx = 0;
        step(I_START, 3'd1, 1'b0, 1'b0, 1'b0, 0);
        for (int k = 1; k <= 4; k++) begin
            step(I_A, 3'd2, 1'b1, 1'b0, 1'b0, k - 1);
            step(I_B, 3'd1, 1'b0, 1'b0, 1'b0, k);
        end
        step(I_PAUSE, 3'd3, 1'b0, 1'b0, 1'b0, 4);
        step(I_PAUSE, 3'd0, 1'b0, 1'b0, 1'b0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL saturation[%0d] got %p expected %p", idx, o, e);
            else         n_pass++;
            idx++;
        end
    endtask

    task automatic test_illegal_and_early_exp();
        obs_t e, o;
        int   idx = 0;
        @(negedge CLK);
        force dut.state_q  = 3'd6;
        force dut2.state_q = 3'd6;
        @(posedge CLK);
        #1;
        release dut.state_q;
        release dut2.state_q;
        n_checks++;
        if (bus.STATE !== 3'd0 || bus2.STATE !== 3'd0)
            $display("FAIL illegal_state got %0d/%0d expected 0/0", bus.STATE, bus2.STATE);
        else
            n_pass++;
        step(I_NONE,          3'd0, 1'b0, 1'b0, 1'b0, 0);
        step(I_START | I_EA,  3'd1, 1'b0, 1'b0, 1'b0, 0);
        step(I_EA,            3'd4, 1'b0, 1'b1, 1'b0, 0);
        step(I_START | I_EA,  3'd0, 1'b0, 1'b0, 1'b0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL early_exp[%0d] got %p expected %p", idx, o, e);
            else         n_pass++;
            idx++;
        end
    endtask

    initial begin
        CLR           = 1'b0;
        bus.TICK      = 1'b0;
        bus.BTN_START = 1'b0;
        bus.BTN_PAUSE = 1'b0;
        bus.BTN_A     = 1'b0;
        bus.BTN_B     = 1'b0;
        bus.EXP_A     = 1'b0;
        bus.EXP_B     = 1'b0;

        test_reset();
        test_turns();
        test_pause();
        test_clr_mid_game();
        test_timeout();
        test_saturation();
        test_illegal_and_early_exp();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
